// File: rtl/cascaded_count_seq.sv
// Cascaded prescaler/stage counter with toggle-flop input channels and a
// run/hold/done sequencer. Channel 0's toggle state forces a stage advance
// every RUN cycle (fast-forward).
module cascaded_count_seq #(
  parameter int unsigned PS_W   = 4,
  parameter int unsigned PS_MAX = 11,
  parameter int unsigned ST_W   = 4,
  parameter int unsigned ST_MAX = 9,
  parameter int unsigned NCH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            start,
  input  logic            pause,
  input  logic            abort,
  input  logic [NCH-1:0]  ch_in,
  output logic [NCH-1:0]  ch_tog,
  output logic [PS_W-1:0] ps_cnt,
  output logic [ST_W-1:0] st_cnt,
  output logic [1:0]      state,
  output logic            tick,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PS_W-1:0] r_ps;
  logic [PS_W-1:0] w_ps_nxt;
  logic [ST_W-1:0] r_st;
  logic [ST_W-1:0] w_st_nxt;
  logic [NCH-1:0]  r_tog;
  logic            r_busy;
  logic            r_done;
  logic            w_adv;
  logic            w_tick;
  logic            w_st_last;

  // Stage-advance condition: prescaler terminal or channel-0 fast-forward
  assign w_adv     = (r_ps == PS_W'(PS_MAX)) | r_tog[0];
  assign w_tick    = w_adv & (r_state == RUN);
  assign w_st_last = (r_st == ST_W'(ST_MAX));

  // Next-state and counter update for the run/hold sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_ps_nxt    = r_ps;
    w_st_nxt    = r_st;
    unique case (r_state)
      IDLE: begin
        w_ps_nxt = '0;
        w_st_nxt = '0;
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_ps_nxt    = '0;
          w_st_nxt    = '0;
        end else if (w_tick && w_st_last) begin
          w_state_nxt = DONE;
          w_ps_nxt    = '0;
          w_st_nxt    = '0;
        end else begin
          // A pause edge still takes this cycle's count/tick
          if (w_tick) begin
            w_ps_nxt = '0;
            w_st_nxt = ST_W'(r_st + 1'b1);
          end else begin
            w_ps_nxt = PS_W'(r_ps + 1'b1);
          end
          if (pause) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_ps_nxt    = '0;
          w_st_nxt    = '0;
        end else if (!pause) begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        w_ps_nxt = '0;
        w_st_nxt = '0;
        if (!abort && start) w_state_nxt = RUN;
        else                 w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ps_nxt    = '0;
        w_st_nxt    = '0;
      end
    endcase
  end

  // State, counters, toggle flops and decoded status registers
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_state <= IDLE;
      r_ps    <= '0;
      r_st    <= '0;
      r_tog   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ps    <= w_ps_nxt;
      r_st    <= w_st_nxt;
      r_tog   <= r_tog ^ ch_in;
      r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == HOLD);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign ch_tog = r_tog;
  assign ps_cnt = r_ps;
  assign st_cnt = r_st;
  assign state  = r_state;
  assign tick   = w_tick;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_cascaded_count_seq.sv
// Bench for cascaded_count_seq: default instance and a reduced-parameter
// instance, checked against a cycle-level integer reference model plus
// closed-form timing expectations.
module tb_cascaded_count_seq;

  logic       clk = 1'b0;
  logic       sel;
  logic       i_rst_n, i_clr, i_start, i_pause, i_abort;
  logic [2:0] i_ch_in;
  logic       w_rst0, w_rst1;

  logic [1:0] d0_tog;
  logic [3:0] d0_ps, d0_st;
  logic [1:0] d0_state;
  logic       d0_tick, d0_busy, d0_done;
  logic [2:0] d1_tog;
  logic [2:0] d1_ps;
  logic [1:0] d1_st;
  logic [1:0] d1_state;
  logic       d1_tick, d1_busy, d1_done;

  logic [28:0] obs;
  int checks = 0;
  int fails  = 0;

  // Reference model state
  int m_state, m_ps, m_st, m_tog;

  always #5 clk = ~clk;

  assign w_rst0 = (sel == 1'b0) ? i_rst_n : 1'b0;
  assign w_rst1 = (sel == 1'b1) ? i_rst_n : 1'b0;

  cascaded_count_seq dut0 (
    .clk(clk), .rst_n(w_rst0), .clr(i_clr), .start(i_start), .pause(i_pause),
    .abort(i_abort), .ch_in(i_ch_in[1:0]), .ch_tog(d0_tog), .ps_cnt(d0_ps),
    .st_cnt(d0_st), .state(d0_state), .tick(d0_tick), .busy(d0_busy), .done(d0_done)
  );

  cascaded_count_seq #(.PS_W(3), .PS_MAX(4), .ST_W(2), .ST_MAX(3), .NCH(3)) dut1 (
    .clk(clk), .rst_n(w_rst1), .clr(i_clr), .start(i_start), .pause(i_pause),
    .abort(i_abort), .ch_in(i_ch_in), .ch_tog(d1_tog), .ps_cnt(d1_ps),
    .st_cnt(d1_st), .state(d1_state), .tick(d1_tick), .busy(d1_busy), .done(d1_done)
  );

  assign obs = sel ? {d1_state, 8'(d1_ps), 8'(d1_st), 8'(d1_tog), d1_tick, d1_busy, d1_done}
                   : {d0_state, 8'(d0_ps), 8'(d0_st), 8'(d0_tog), d0_tick, d0_busy, d0_done};

  function automatic int ps_max(); return sel ? 4 : 11; endfunction
  function automatic int st_max(); return sel ? 3 : 9;  endfunction
  function automatic int ch_mask(); return sel ? 7 : 3; endfunction

  function automatic logic m_tick();
    return (m_state == 1) && ((m_ps == ps_max()) || ((m_tog & 1) != 0));
  endfunction

  function automatic logic [28:0] exp_vec();
    logic bz, dn;
    bz = (m_state == 1) || (m_state == 2);
    dn = (m_state == 3);
    return {2'(m_state), 8'(m_ps), 8'(m_st), 8'(m_tog), m_tick(), bz, dn};
  endfunction

  // Behavioural model: one clock edge of the sequencer rules, in integers
  task automatic model_edge();
    logic tk;
    if (!i_rst_n || i_clr) begin
      m_state = 0; m_ps = 0; m_st = 0; m_tog = 0;
      return;
    end
    tk = m_tick();
    m_tog = m_tog ^ (int'(i_ch_in) & ch_mask());
    case (m_state)
      0: begin m_ps = 0; m_st = 0; if (i_start) m_state = 1; end
      1: begin
        if (i_abort) begin m_state = 0; m_ps = 0; m_st = 0; end
        else if (tk && m_st == st_max()) begin m_state = 3; m_ps = 0; m_st = 0; end
        else begin
          if (tk) begin m_ps = 0; m_st = m_st + 1; end
          else m_ps = m_ps + 1;
          if (i_pause) m_state = 2;
        end
      end
      2: begin
        if (i_abort) begin m_state = 0; m_ps = 0; m_st = 0; end
        else if (!i_pause) m_state = 1;
      end
      default: begin
        m_ps = 0; m_st = 0;
        m_state = (!i_abort && i_start) ? 1 : 0;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i_rst_n = 1'b1; i_clr = 1'b0; i_start = 1'b0; i_pause = 1'b0;
    i_abort = 1'b0; i_ch_in = 3'b000;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    checks++;
    if (obs !== 29'd0) begin fails++; $display("FAIL reset_init obs=%h exp=0", obs); end
    // Reach RUN with both toggles set, then reset and then clear
    for (int pass = 0; pass < 2; pass++) begin
      i_start = 1'b1; i_ch_in = 3'b011;
      step();
      i_start = 1'b0; i_ch_in = 3'b000;
      step();
      checks++;
      if (d0_state !== 2'd1 || d0_tog !== 2'b11) begin
        fails++; $display("FAIL reset_pre state=%0d tog=%b exp 1/11", d0_state, d0_tog);
      end
      if (pass == 0) i_rst_n = 1'b0; else i_clr = 1'b1;
      i_ch_in = 3'b011; i_start = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (obs !== 29'd0 || obs !== exp_vec()) begin
        fails++; $display("FAIL reset_%s obs=%h exp=0", pass ? "clr" : "rst", obs);
      end
    end
  endtask

  task automatic test_full_pass();
    sel = 1'b0;
    do_reset();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 1; c <= 121; c++) begin
      logic [28:0] ex;
      logic        ext, exd;
      logic [3:0]  exps, exst;
      ext  = (c % 12 == 0) && (c <= 120);
      exd  = (c == 121);
      exps = (c == 121) ? 4'd0 : 4'((c - 1) % 12);
      exst = (c == 121) ? 4'd0 : 4'((c - 1) / 12);
      ex = exp_vec();
      checks++;
      if (obs !== ex || d0_tick !== ext || d0_done !== exd || d0_ps !== exps || d0_st !== exst) begin
        fails++;
        $display("FAIL full_pass c=%0d obs=%h model=%h tick=%b/%b done=%b/%b ps=%0d/%0d st=%0d/%0d",
                 c, obs, ex, d0_tick, ext, d0_done, exd, d0_ps, exps, d0_st, exst);
      end
      if (c < 121) step();
    end
    step();
    checks++;
    if (d0_state !== 2'd0 || d0_done !== 1'b0) begin
      fails++; $display("FAIL full_pass_end state=%0d exp 0", d0_state);
    end
  endtask

  task automatic test_auto_restart();
    logic prev_done;
    sel = 1'b0;
    do_reset();
    i_start = 1'b1;
    step();
    prev_done = 1'b0;
    for (int c = 1; c <= 250; c++) begin
      checks++;
      if (obs !== exp_vec() || (prev_done && d0_done) ||
          d0_done !== ((c == 121) || (c == 242))) begin
        fails++; $display("FAIL auto_restart c=%0d obs=%h model=%h done=%b", c, obs, exp_vec(), d0_done);
      end
      if (c == 122) begin
        checks++;
        if (d0_state !== 2'd1 || d0_ps !== 4'd0 || d0_st !== 4'd0) begin
          fails++; $display("FAIL restart_run state=%0d ps=%0d st=%0d exp 1/0/0", d0_state, d0_ps, d0_st);
        end
      end
      prev_done = d0_done;
      step();
    end
    i_start = 1'b0;
  endtask

  task automatic test_fast_forward();
    int done_n;
    sel = 1'b0;
    do_reset();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    i_ch_in = 3'b001;
    step();
    i_ch_in = 3'b000;
    checks++;
    if (d0_tog[0] !== 1'b1 || d0_ps !== 4'd4 || d0_st !== 4'd0 || d0_tick !== 1'b1) begin
      fails++; $display("FAIL ff_rise tog=%b ps=%0d st=%0d tick=%b exp 1/4/0/1", d0_tog, d0_ps, d0_st, d0_tick);
    end
    done_n = -1;
    for (int n = 1; n <= 14 && done_n < 0; n++) begin
      step();
      checks++;
      if (obs !== exp_vec() || (n < 10 && (d0_st !== 4'(n) || d0_tick !== 1'b1))) begin
        fails++; $display("FAIL ff_step n=%0d obs=%h model=%h st=%0d", n, obs, exp_vec(), d0_st);
      end
      if (d0_done) done_n = n;
    end
    checks++;
    if (done_n != 10) begin fails++; $display("FAIL ff_done_latency got=%0d exp=10", done_n); end
    step();
    i_ch_in = 3'b001;
    step();
    i_ch_in = 3'b000;
    checks++;
    if (d0_tog[0] !== 1'b0 || d0_state !== 2'd0) begin
      fails++; $display("FAIL ff_untoggle tog=%b state=%0d exp 0/0", d0_tog, d0_state);
    end
  endtask

  task automatic test_pause_abort();
    sel = 1'b0;
    do_reset();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 11; k++) step();
    checks++;
    if (d0_ps !== 4'd11) begin fails++; $display("FAIL pause_pre ps=%0d exp 11", d0_ps); end
    i_pause = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (d0_state !== 2'd2 || d0_ps !== 4'd0 || d0_st !== 4'd1 || d0_tick !== 1'b0 ||
          d0_busy !== 1'b1 || obs !== exp_vec()) begin
        fails++; $display("FAIL hold k=%0d state=%0d ps=%0d st=%0d tick=%b exp 2/0/1/0", k, d0_state, d0_ps, d0_st, d0_tick);
      end
    end
    i_pause = 1'b0;
    step();
    checks++;
    if (d0_state !== 2'd1 || d0_ps !== 4'd0 || d0_st !== 4'd1) begin
      fails++; $display("FAIL resume state=%0d ps=%0d st=%0d exp 1/0/1", d0_state, d0_ps, d0_st);
    end
    step(); step();
    i_pause = 1'b1; i_abort = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (d0_state !== 2'd0 || d0_ps !== 4'd0 || d0_st !== 4'd0 || d0_busy !== 1'b0) begin
      fails++; $display("FAIL abort state=%0d ps=%0d st=%0d exp 0/0/0", d0_state, d0_ps, d0_st);
    end
  endtask

  task automatic test_param();
    sel = 1'b1;
    do_reset();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      checks++;
      if (obs !== exp_vec() || d1_done !== (c == 21) || d1_tick !== ((c % 5 == 0) && c <= 20)) begin
        fails++; $display("FAIL param c=%0d obs=%h model=%h tick=%b done=%b", c, obs, exp_vec(), d1_tick, d1_done);
      end
      if (c == 9) begin
        checks++;
        if (d1_tog !== 3'b100) begin fails++; $display("FAIL param_ch2 tog=%b exp 100", d1_tog); end
      end
      i_ch_in = (c == 8) ? 3'b100 : 3'b000;
      if (c < 21) step();
    end
    i_ch_in = 3'b000;
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int k = 0; k < 600; k++) begin
        i_rst_n = ($urandom % 97) != 0;
        i_clr   = ($urandom % 89) == 0;
        i_start = ($urandom % 3) == 0;
        i_pause = ($urandom % 7) == 0;
        i_abort = ($urandom % 40) == 0;
        i_ch_in = (($urandom % 9) == 0) ? 3'($urandom) : 3'b000;
        step();
        checks++;
        if (obs !== exp_vec()) begin
          fails++; $display("FAIL random sel=%0d k=%0d obs=%h model=%h", s, k, obs, exp_vec());
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    sel = 1'b0;
    idle_inputs();
    m_state = 0; m_ps = 0; m_st = 0; m_tog = 0;
    #1;
    test_reset();
    test_full_pass();
    test_auto_restart();
    test_fast_forward();
    test_pause_abort();
    test_param();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/cascaded_count_seq.md
Name: cascaded_count_seq

Overview:
- Parametrised successor to the team's fixed-width cascaded-counter controller: a prescaler counter, a stage counter, NCH toggle-flop input channels and a 4-state run/hold sequencer.
- Channel 0's toggle state fast-forwards the stage counter, as in the previous generation.
- Sits between pad-level control inputs and downstream timing logic; produces stage, tick and done status.
- New relative to the previous generation: configurable widths and terminal counts, pause/hold, abort, and auto-restart.

Parameters:
- PS_W, 4, prescaler width in bits.
- PS_MAX, 11, prescaler terminal value; must be < 2**PS_W.
- ST_W, 4, stage counter width in bits.
- ST_MAX, 9, stage terminal value; must be < 2**ST_W.
- NCH, 2, number of toggle-flop input channels; must be >= 1.

Ports:
- clk, in, 1, sole clock; all state updates on rising edge.
- rst_n, in, 1, synchronous active-low reset.
- clr, in, 1, synchronous active-high clear; same effect as reset.
- start, in, 1, leave IDLE / auto-restart request.
- pause, in, 1, RUN→HOLD request; holding in HOLD while 1.
- abort, in, 1, return to IDLE and zero the counters.
- ch_in, in, NCH, per-channel toggle enables.
- ch_tog, out, NCH, registered toggle-flop states.
- ps_cnt, out, PS_W, prescaler value.
- st_cnt, out, ST_W, stage value.
- state, out, 2, encoding IDLE=0, RUN=1, HOLD=2, DONE=3.
- tick, out, 1, combinational: stage-advance condition in RUN.
- busy, out, 1, high when state is RUN or HOLD.
- done, out, 1, high exactly while state==DONE (one cycle).

Behaviour:
- Reset (rst_n=0) or clr=1 at an edge:
  - state=IDLE, ps_cnt=0, st_cnt=0, ch_tog=0.
  - Consequently tick=0, busy=0, done=0.
  - Reset takes precedence over clr; both take precedence over every other input.
  - Mid-operation reset/clr discards all progress; there is no partial-hold.
- Channels: every edge, ch_tog[i] <= ch_tog[i] ^ ch_in[i]. This holds in all states except reset/clr.
- Advance condition: adv = (ps_cnt==PS_MAX) | ch_tog[0].
  - tick = adv & (state==RUN).
- IDLE:
  - ps_cnt and st_cnt held at 0.
  - start=1 → RUN; abort has no additional effect.
- RUN, per edge, in priority order:
  - abort=1: → IDLE; ps_cnt=0, st_cnt=0.
  - Else if tick and st_cnt==ST_MAX: → DONE; ps_cnt=0, st_cnt=0.
  - Else if tick: ps_cnt=0, st_cnt+1.
  - Else: ps_cnt+1.
  - If pause=1 and not aborting/finishing, the next state is HOLD, but the counter update of this same cycle still applies (the pause edge's tick is not lost).
- HOLD:
  - Counters frozen; tick=0 even if adv is true.
  - abort=1 → IDLE with counters zeroed.
  - Else pause=0 → RUN.
  - Else stay in HOLD.
- DONE (one cycle):
  - start=1 → RUN (auto-restart; counters already 0).
  - Else → IDLE.
  - abort=1 forces IDLE.
- Arithmetic: all counters are unsigned. ps_cnt never exceeds PS_MAX and st_cnt never exceeds ST_MAX under legal operation.
- With ch_tog[0]=1 held, every RUN cycle ticks: a full pass takes ST_MAX+1 cycles.
- Latency: RUN entered one edge after start. Full pass without fast-forward = (PS_MAX+1)*(ST_MAX+1) RUN cycles, followed by one DONE cycle.

Test Plan:
- Reset/clear: apply rst_n=0 with ch_tog previously 2'b11 and state RUN → next edge all outputs 0, state=IDLE; repeat using clr=1 with rst_n=1 → same result.
- Full pass, defaults, start pulse in cycle 0, ch_in=0:
  - state=RUN from cycle 1.
  - tick in cycles 12, 24, …, 120.
  - st_cnt reaches 9 after cycle 108.
  - done=1 only in cycle 121, then IDLE.
- Auto-restart: start held at 1 → DONE at cycle 121 followed by RUN at cycle 122 with ps_cnt=0, st_cnt=0; done is never high for 2 consecutive cycles.
- Fast-forward: in RUN with ps_cnt=3, st_cnt=0, pulse ch_in[0]=1 for one cycle →
  - ch_tog[0]=1 from the next cycle;
  - tick every cycle; st_cnt steps 1..9;
  - DONE 10 cycles after ch_tog[0] rose.
  - Then pulse ch_in[0] again → ch_tog[0]=0.
- Pause/abort:
  - Assert pause on the cycle ps_cnt==11 → st_cnt increments, state=HOLD, counters frozen for 5 cycles.
  - Deassert pause → RUN resumes with ps_cnt=0.
  - Then abort=1 together with pause=1 → IDLE, counters 0.
- Parametrisation: PS_W=3, PS_MAX=4, ST_W=2, ST_MAX=3, NCH=3 → done after 20 RUN cycles; ch_tog[2] toggles on ch_in[2] with no effect on tick.
